tlb_napot: RTL and testbench
============================

// Module: tlb_napot
// PURPOSE
//  Fully associative SV39 L1 TLB, next generation: adds Svnapot 64 KiB pages (4K/64K/2M/1G),
//  pow2 depth, tree-PLRU with fill promotion. Sits in the MMU between the LSU/fetch lookup
//  and the PTW refill path; SFENCE.VMA drives flush_i. Lookup is combinational, state updates next edge.
// PARAMETERS
//  TLB_ENTRIES  8  entry count; power of 2, >=2
//  ASID_WIDTH   1  ASID bits; >=1
// PORTS
//  clk_i                  in   1            clock
//  rst_ni                 in   1            reset, asynchronous, active-low
//  flush_i                in   1            SFENCE.VMA strobe (one cycle)
//  update_i               in   tlb_napot_update_t  PTW refill {valid,is_1G,is_2M,is_64K,vpn[26:0],asid,content}
//  lu_access_i            in   1            lookup qualifies PLRU update
//  lu_asid_i              in   ASID_WIDTH   lookup ASID
//  lu_vaddr_i             in   VLEN         lookup VA
//  asid_to_be_flushed_i   in   ASID_WIDTH   SFENCE rs2
//  vaddr_to_be_flushed_i  in   VLEN         SFENCE rs1
//  lu_content_o           out  pte_t        hit PTE; PPN[3:0] patched for 64K hits
//  lu_is_64K_o            out  1            hit is NAPOT 64 KiB
//  lu_is_2M_o             out  1            hit is 2 MiB
//  lu_is_1G_o             out  1            hit is 1 GiB
//  lu_hit_o               out  1            any entry matched
// BEHAVIOUR
//  - Reset: all tags invalid, content 0, PLRU tree 0 (victim = entry 0); all outputs 0 while no valid entry.
//  - Match(i): valid & (asid==lu_asid | g) & vpn2 eq & (1G | vpn1 eq & (2M | 64K&vpn0[8:4] eq | vpn0 eq)).
//  - Hit outputs same cycle; miss -> all outputs 0. At most one match by construction (PTW never refills a hit).
//  - 64K hit: lu_content_o.ppn[3:0] = lu_vaddr_i[15:12]; other PTE fields as stored.
//  - Refill: update_i.valid & !flush_i -> write victim entry next edge; for is_64K store vpn0[3:0]=0.
//    Priority of size flags 1G > 2M > 64K; extras ignored.
//  - PLRU: lu_access_i & hit -> path to hit entry marked MRU next edge; refill also marks victim MRU.
//    Lookup hit and refill same cycle: refill path written last (wins on shared nodes).
//  - Flush (flush_i, one cycle, overrides refill; refill that cycle is dropped, PTW re-walks):
//      asid==0 & va==0  -> invalidate all
//      asid==0 & va!=0  -> invalidate entries whose page (size-aware, incl. 64K range) covers va
//      asid!=0 & va!=0  -> as above but only non-global entries with asid eq
//      asid!=0 & va==0  -> non-global entries with asid eq
//    Lookup in flush cycle still returns pre-flush contents; PLRU not cleared by flush.
//  - Reset mid-refill/flush: asynchronous clear, pending operation lost.
// CONFIGURATION
//  - TLB_NAPOT_EN defined: 64K matching, PPN patching, 64K-range flush as above.
//  - Undefined: is_64K ignored (entry stored/treated as 4K, full vpn0 stored), lu_is_64K_o tied 0.
// STRUCTURE
//  - ariane_pkg: tlb_napot_update_t, NAPOT_BITS=4 constant, tlb_napot_tag_t typedef.
//  - Sub-module tlb_plru_tree #(ENTRIES): hit/fill one-hot in -> replace_en one-hot out; reused by L2 TLB.
//  - SVA (non-Verilator): $onehot0(hit vector), $onehot(replace_en), parameter checks.
// TESTING
//  - Reset, lookup va=0x8000_1000 -> lu_hit_o=0, all outputs 0.
//  - Refill 64K vpn=0x00012 ppn=0x80050 asid=1; lookup va=0x1_7000 asid=1 -> hit, is_64K=1, ppn=0x80057.
//  - Same entry, lookup asid=2 (g=0) -> miss; with g=1 -> hit.
//  - Fill 8 entries then hit entries 0..6 -> next refill replaces entry 7.
//  - Flush asid=0 va=0x1_3000 -> 64K entry invalid; 2M entry va 0x4000_0000 stays; refill same cycle dropped.
//  - Flush asid=1 va=0 -> non-global asid 1 entries gone; global and asid 3 entries still hit.

Source files
------------

// File: rtl/tlb_napot_pkg.sv
// Shared types for the SV39 L1 TLB with Svnapot 64 KiB page support.
//   pte_t               : SV39 page table entry as stored in the TLB
//   tlb_napot_update_t  : PTW refill payload
//   tlb_napot_tag_t     : per-entry tag (validity, page size, VPN slices)
// 64 KiB NAPOT support in the TLB itself is enabled by defining TLB_NAPOT_EN.
package tlb_napot_pkg;

  localparam int unsigned VLEN       = 39;
  localparam int unsigned PPN_WIDTH  = 44;
  localparam int unsigned VPN_WIDTH  = 27;
  localparam int unsigned VPN_SLICE  = 9;
  localparam int unsigned ASID_MAX   = 16;
  localparam int unsigned NAPOT_BITS = 4;

  typedef struct packed {
    logic [9:0]           reserved;
    logic [PPN_WIDTH-1:0] ppn;
    logic [1:0]           rsw;
    logic                 d;
    logic                 a;
    logic                 g;
    logic                 u;
    logic                 x;
    logic                 w;
    logic                 r;
    logic                 v;
  } pte_t;

  typedef struct packed {
    logic                 valid;
    logic                 is_1G;
    logic                 is_2M;
    logic                 is_64K;
    logic [VPN_WIDTH-1:0] vpn;
    logic [ASID_MAX-1:0]  asid;
    pte_t                 content;
  } tlb_napot_update_t;

  typedef struct packed {
    logic                 valid;
    logic                 is_1G;
    logic                 is_2M;
    logic                 is_64K;
    logic [VPN_SLICE-1:0] vpn2;
    logic [VPN_SLICE-1:0] vpn1;
    logic [VPN_SLICE-1:0] vpn0;
  } tlb_napot_tag_t;

endpackage

// File: rtl/tlb_plru_tree.sv
// Tree pseudo-LRU replacement for a power-of-two number of ways.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   hit_i          : one-hot (or zero) way to mark most-recently used
//   fill_i         : one-hot (or zero) way being filled; applied after hit_i
//   replace_en_o   : one-hot victim way derived from the current tree
// Node bit b steers the victim search to child b (0 = lower half). Marking a way
// MRU writes every node on its path to point away from it.
module tlb_plru_tree #(
  parameter int unsigned ENTRIES = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [ENTRIES-1:0] hit_i,
  input  logic [ENTRIES-1:0] fill_i,
  output logic [ENTRIES-1:0] replace_en_o
);

  localparam int unsigned LOG   = $clog2(ENTRIES);
  localparam int unsigned NODES = ENTRIES - 1;

  logic [NODES-1:0] tree_q;
  logic [NODES-1:0] tree_d;

  // Victim: the way whose whole path agrees with the stored steering bits.
  always_comb begin : victim_sel
    replace_en_o = '1;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      for (int unsigned lvl = 0; lvl < LOG; lvl++) begin
        if (tree_q[(1 << lvl) - 1 + (i >> (LOG - lvl))] != 1'(i >> (LOG - lvl - 1))) begin
          replace_en_o[i] = 1'b0;
        end
      end
    end
  end

  // Lookup hit path first, fill path last so the fill wins on shared nodes.
  always_comb begin : tree_next
    tree_d = tree_q;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (hit_i[i]) begin
        for (int unsigned lvl = 0; lvl < LOG; lvl++) begin
          tree_d[(1 << lvl) - 1 + (i >> (LOG - lvl))] = ~1'(i >> (LOG - lvl - 1));
        end
      end
    end
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (fill_i[i]) begin
        for (int unsigned lvl = 0; lvl < LOG; lvl++) begin
          tree_d[(1 << lvl) - 1 + (i >> (LOG - lvl))] = ~1'(i >> (LOG - lvl - 1));
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : tree_reg
    if (!rst_ni) begin
      tree_q <= '0;
    end else begin
      tree_q <= tree_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot(replace_en_o))
    else $error("replace_en_o not one-hot");

endmodule

// File: rtl/tlb_napot.sv
// Fully associative SV39 L1 TLB with 4K / 64K (Svnapot) / 2M / 1G pages.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   flush_i                  : SFENCE.VMA strobe, qualified by asid/vaddr_to_be_flushed_i
//   update_i                 : PTW refill written into the PLRU victim
//   lu_access_i              : qualifies a lookup hit for the PLRU update
//   lu_asid_i, lu_vaddr_i    : combinational lookup key
//   lu_content_o, lu_is_*_o  : hit PTE and page size (all zero on a miss)
//   lu_hit_o                 : lookup matched an entry
// Macro TLB_NAPOT_EN enables 64K matching, PPN patching and 64K-range flushes;
// without it a 64K refill is stored and treated as a plain 4K page.
module tlb_napot
  import tlb_napot_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = 8,
  parameter int unsigned ASID_WIDTH  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  tlb_napot_update_t     update_i,
  input  logic                  lu_access_i,
  input  logic [ASID_WIDTH-1:0] lu_asid_i,
  input  logic [VLEN-1:0]       lu_vaddr_i,
  input  logic [ASID_WIDTH-1:0] asid_to_be_flushed_i,
  input  logic [VLEN-1:0]       vaddr_to_be_flushed_i,
  output pte_t                  lu_content_o,
  output logic                  lu_is_64K_o,
  output logic                  lu_is_2M_o,
  output logic                  lu_is_1G_o,
  output logic                  lu_hit_o
);

  tlb_napot_tag_t        tag_q     [TLB_ENTRIES];
  tlb_napot_tag_t        tag_d     [TLB_ENTRIES];
  pte_t                  content_q [TLB_ENTRIES];
  pte_t                  content_d [TLB_ENTRIES];
  logic [ASID_WIDTH-1:0] asid_q    [TLB_ENTRIES];
  logic [ASID_WIDTH-1:0] asid_d    [TLB_ENTRIES];

  logic [TLB_ENTRIES-1:0] lu_hit;
  logic [TLB_ENTRIES-1:0] flush_inv;
  logic [TLB_ENTRIES-1:0] replace_en;
  logic [TLB_ENTRIES-1:0] plru_hit;
  logic [TLB_ENTRIES-1:0] plru_fill;
  logic [VPN_WIDTH-1:0]   lu_vpn;
  logic [VPN_WIDTH-1:0]   flush_vpn;
  logic                   refill_en;
  logic                   flush_asid_zero;
  logic                   flush_va_zero;
  tlb_napot_tag_t         new_tag;

  assign lu_vpn          = lu_vaddr_i[VLEN-1:12];
  assign flush_vpn       = vaddr_to_be_flushed_i[VLEN-1:12];
  assign refill_en       = update_i.valid & ~flush_i;
  assign flush_asid_zero = (asid_to_be_flushed_i == '0);
  assign flush_va_zero   = (vaddr_to_be_flushed_i == '0);

  // Page-offset bits and the unused upper ASID bits of the refill payload.
  logic unused_bits;
  assign unused_bits = ^{lu_vaddr_i[11:0], update_i.asid, update_i.is_64K};

  // Size-aware VPN compare; is_64K is only ever set when NAPOT support is built in.
  function automatic logic page_match(tlb_napot_tag_t t, logic [VPN_WIDTH-1:0] vpn);
    logic vpn0_eq;
    vpn0_eq = (t.vpn0 == vpn[8:0]) | (t.is_64K & (t.vpn0[8:NAPOT_BITS] == vpn[8:NAPOT_BITS]));
    return (t.vpn2 == vpn[26:18]) & (t.is_1G | ((t.vpn1 == vpn[17:9]) & (t.is_2M | vpn0_eq)));
  endfunction

  // Per-entry lookup match and flush selection.
  always_comb begin : match
    lu_hit    = '0;
    flush_inv = '0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      lu_hit[i] = tag_q[i].valid & ((asid_q[i] == lu_asid_i) | content_q[i].g)
                  & page_match(tag_q[i], lu_vpn);
      if (flush_asid_zero) begin
        flush_inv[i] = flush_va_zero | page_match(tag_q[i], flush_vpn);
      end else begin
        flush_inv[i] = ~content_q[i].g & (asid_q[i] == asid_to_be_flushed_i)
                       & (flush_va_zero | page_match(tag_q[i], flush_vpn));
      end
    end
  end

  // Hit mux; the hit vector is at most one-hot so plain overwrite is safe.
  always_comb begin : lookup_out
    lu_hit_o     = 1'b0;
    lu_content_o = '0;
    lu_is_1G_o   = 1'b0;
    lu_is_2M_o   = 1'b0;
    lu_is_64K_o  = 1'b0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      if (lu_hit[i]) begin
        lu_hit_o     = 1'b1;
        lu_content_o = content_q[i];
        lu_is_1G_o   = tag_q[i].is_1G;
        lu_is_2M_o   = tag_q[i].is_2M;
`ifdef TLB_NAPOT_EN
        lu_is_64K_o  = tag_q[i].is_64K;
`endif
      end
    end
`ifdef TLB_NAPOT_EN
    // Within a 64K page the low PPN bits follow the VA, the stored ones are ignored.
    if (lu_is_64K_o) begin
      lu_content_o.ppn[NAPOT_BITS-1:0] = lu_vpn[NAPOT_BITS-1:0];
    end
`endif
  end

  // Refill tag: resolve size flags by priority, align 64K VPNs.
  always_comb begin : refill_tag
    new_tag        = '0;
    new_tag.valid  = 1'b1;
    new_tag.is_1G  = update_i.is_1G;
    new_tag.is_2M  = ~update_i.is_1G & update_i.is_2M;
    new_tag.vpn2   = update_i.vpn[26:18];
    new_tag.vpn1   = update_i.vpn[17:9];
    new_tag.vpn0   = update_i.vpn[8:0];
`ifdef TLB_NAPOT_EN
    new_tag.is_64K = ~update_i.is_1G & ~update_i.is_2M & update_i.is_64K;
    if (new_tag.is_64K) begin
      new_tag.vpn0[NAPOT_BITS-1:0] = '0;
    end
`endif
  end

  // Entry next state: flush invalidates and drops any same-cycle refill.
  always_comb begin : entry_next
    tag_d     = tag_q;
    content_d = content_q;
    asid_d    = asid_q;
    if (flush_i) begin
      for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
        if (flush_inv[i]) begin
          tag_d[i].valid = 1'b0;
        end
      end
    end else if (update_i.valid) begin
      for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
        if (replace_en[i]) begin
          tag_d[i]     = new_tag;
          content_d[i] = update_i.content;
          asid_d[i]    = update_i.asid[ASID_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : entry_reg
    if (!rst_ni) begin
      for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
        tag_q[i]     <= '0;
        content_q[i] <= '0;
        asid_q[i]    <= '0;
      end
    end else begin
      tag_q     <= tag_d;
      content_q <= content_d;
      asid_q    <= asid_d;
    end
  end

  assign plru_hit  = lu_hit & {TLB_ENTRIES{lu_access_i}};
  assign plru_fill = replace_en & {TLB_ENTRIES{refill_en}};

  tlb_plru_tree #(
    .ENTRIES (TLB_ENTRIES)
  ) u_plru (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .hit_i        (plru_hit),
    .fill_i       (plru_fill),
    .replace_en_o (replace_en)
  );

  if (TLB_ENTRIES < 2 || (TLB_ENTRIES & (TLB_ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("TLB_ENTRIES must be a power of two >= 2");
  end
  if (ASID_WIDTH < 1 || ASID_WIDTH > ASID_MAX) begin : g_bad_asid
    $error("ASID_WIDTH out of range");
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(lu_hit))
    else $error("multiple TLB entries hit");

endmodule

// File: tb/tb_tlb_napot.sv
module tb_tlb_napot;
  import tlb_napot_pkg::*;

  localparam int unsigned ENTRIES = 8;
  localparam int unsigned AW      = 4;
`ifdef TLB_NAPOT_EN
  localparam bit NAPOT = 1'b1;
`else
  localparam bit NAPOT = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  tlb_napot_update_t update_i;
  logic              lu_access_i;
  logic [AW-1:0]     lu_asid_i;
  logic [VLEN-1:0]   lu_vaddr_i;
  logic [AW-1:0]     asid_to_be_flushed_i;
  logic [VLEN-1:0]   vaddr_to_be_flushed_i;
  pte_t              lu_content_o;
  logic              lu_is_64K_o;
  logic              lu_is_2M_o;
  logic              lu_is_1G_o;
  logic              lu_hit_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  tlb_napot #(
    .TLB_ENTRIES (ENTRIES),
    .ASID_WIDTH  (AW)
  ) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .update_i              (update_i),
    .lu_access_i           (lu_access_i),
    .lu_asid_i             (lu_asid_i),
    .lu_vaddr_i            (lu_vaddr_i),
    .asid_to_be_flushed_i  (asid_to_be_flushed_i),
    .vaddr_to_be_flushed_i (vaddr_to_be_flushed_i),
    .lu_content_o          (lu_content_o),
    .lu_is_64K_o           (lu_is_64K_o),
    .lu_is_2M_o            (lu_is_2M_o),
    .lu_is_1G_o            (lu_is_1G_o),
    .lu_hit_o              (lu_hit_o)
  );

  function automatic pte_t mk_pte(input logic [43:0] ppn, input logic g);
    pte_t p;
    p     = '0;
    p.ppn = ppn;
    p.g   = g;
    p.d   = 1'b1;
    p.a   = 1'b1;
    p.w   = 1'b1;
    p.r   = 1'b1;
    p.v   = 1'b1;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i               = 1'b0;
    update_i              = '0;
    lu_access_i           = 1'b0;
    asid_to_be_flushed_i  = '0;
    vaddr_to_be_flushed_i = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic refill(input logic [26:0] vpn, input logic [AW-1:0] asid,
                        input logic s1g, input logic s2m, input logic s64k, input pte_t c);
    update_i.valid   = 1'b1;
    update_i.is_1G   = s1g;
    update_i.is_2M   = s2m;
    update_i.is_64K  = s64k;
    update_i.vpn     = vpn;
    update_i.asid    = 16'(asid);
    update_i.content = c;
    step();
    update_i = '0;
  endtask

  task automatic look(input logic [VLEN-1:0] va, input logic [AW-1:0] asid);
    lu_vaddr_i = va;
    lu_asid_i  = asid;
    #1;
  endtask

  task automatic expect_lu(input string tag, input logic h, input pte_t c,
                           input logic f64, input logic f2, input logic f1);
    chk({tag, ".hit"}, 64'(lu_hit_o), 64'(h));
    chk({tag, ".pte"}, 64'(lu_content_o), h ? 64'(c) : 64'h0);
    chk({tag, ".64K"}, 64'(lu_is_64K_o), 64'(h & f64));
    chk({tag, ".2M"},  64'(lu_is_2M_o),  64'(h & f2));
    chk({tag, ".1G"},  64'(lu_is_1G_o),  64'(h & f1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int ord[7];
    rst_ni     = 1'b0;
    lu_vaddr_i = '0;
    lu_asid_i  = '0;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Reset state: nothing hits, all outputs zero.
    look(39'h0_8000_1000, 4'd0);
    expect_lu("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // 64K page vpn 0x12 (range 0x10..0x1F), ppn 0x80050, asid 1.
    refill(27'h12, 4'd1, 1'b0, 1'b0, 1'b1, mk_pte(44'h80050, 1'b0));
    look(39'h0_0001_7000, 4'd1);
    expect_lu("napot_17", NAPOT, mk_pte(44'h80057, 1'b0), 1'b1, 1'b0, 1'b0);
    look(39'h0_0001_2000, 4'd1);
    expect_lu("napot_12", 1'b1, mk_pte(NAPOT ? 44'h80052 : 44'h80050, 1'b0), NAPOT, 1'b0, 1'b0);
    look(39'h0_0001_F000, 4'd1);
    expect_lu("napot_top", NAPOT, mk_pte(44'h8005F, 1'b0), 1'b1, 1'b0, 1'b0);
    look(39'h0_0002_0000, 4'd1);
    expect_lu("napot_above", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    look(39'h0_0000_F000, 4'd1);
    expect_lu("napot_below", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    look(39'h0_0001_2000, 4'd2);
    expect_lu("asid_miss", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Same page global: other ASID hits.
    do_reset();
    refill(27'h12, 4'd1, 1'b0, 1'b0, 1'b1, mk_pte(44'h80050, 1'b1));
    look(39'h0_0001_2000, 4'd2);
    expect_lu("global_hit", 1'b1, mk_pte(NAPOT ? 44'h80052 : 44'h80050, 1'b1), NAPOT, 1'b0, 1'b0);

    // PLRU: fills from reset land in entries 0,4,2,6,1,5,3,7. Touching entries
    // 6,4,5,0,1,2,3 (pages 3,1,5,0,4,2,6) leaves entry 7 (page 7) as victim.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      refill(27'h100 + 27'(k), 4'd1, 1'b0, 1'b0, 1'b0, mk_pte(44'h1000 + 44'(k), 1'b0));
    end
    ord = '{3, 1, 5, 0, 4, 2, 6};
    for (int j = 0; j < 7; j++) begin
      look({27'h100 + 27'(ord[j]), 12'h000}, 4'd1);
      lu_access_i = 1'b1;
      chk($sformatf("plru_touch%0d", ord[j]), 64'(lu_content_o.ppn), 64'h1000 + 64'(ord[j]));
      step();
      lu_access_i = 1'b0;
    end
    refill(27'h200, 4'd1, 1'b0, 1'b0, 1'b0, mk_pte(44'h2000, 1'b0));
    look(39'h0_0010_7000, 4'd1);
    expect_lu("plru_evicted", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    look(39'h0_0020_0000, 4'd1);
    expect_lu("plru_new", 1'b1, mk_pte(44'h2000, 1'b0), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      look({27'h100 + 27'(k), 12'h000}, 4'd1);
      chk($sformatf("plru_keep%0d", k), 64'(lu_hit_o), 64'h1);
    end

    // Flush by VA: 64K range covered, 2M and 1G untouched, refill dropped.
    do_reset();
    refill(27'h12, 4'd1, 1'b0, 1'b0, 1'b1, mk_pte(44'h80050, 1'b0));
    refill(27'h40000, 4'd1, 1'b0, 1'b1, 1'b1, mk_pte(44'h80200, 1'b0));
    refill(27'h80000, 4'd1, 1'b1, 1'b1, 1'b1, mk_pte(44'h40000, 1'b0));
    look(39'h0_4012_3000, 4'd1);
    expect_lu("2M_hit", 1'b1, mk_pte(44'h80200, 1'b0), 1'b0, 1'b1, 1'b0);
    look(39'h0_BFFF_F000, 4'd1);
    expect_lu("1G_prio", 1'b1, mk_pte(44'h40000, 1'b0), 1'b0, 1'b0, 1'b1);
    flush_i                = 1'b1;
    asid_to_be_flushed_i   = 4'd0;
    vaddr_to_be_flushed_i  = 39'h0_0001_3000;
    update_i.valid         = 1'b1;
    update_i.vpn           = 27'h300;
    update_i.asid          = 16'd1;
    update_i.content       = mk_pte(44'h3000, 1'b0);
    look(39'h0_0001_2000, 4'd1);
    expect_lu("flush_cycle", 1'b1, mk_pte(NAPOT ? 44'h80052 : 44'h80050, 1'b0), NAPOT, 1'b0, 1'b0);
    step();
    idle();
    look(39'h0_0001_2000, 4'd1);
    chk("flush_64K", 64'(lu_hit_o), NAPOT ? 64'h0 : 64'h1);
    look(39'h0_4000_0000, 4'd1);
    expect_lu("flush_2M_keep", 1'b1, mk_pte(44'h80200, 1'b0), 1'b0, 1'b1, 1'b0);
    look(39'h0_BFFF_F000, 4'd1);
    chk("flush_1G_keep", 64'(lu_hit_o), 64'h1);
    look(39'h0_0030_0000, 4'd1);
    chk("flush_drop_refill", 64'(lu_hit_o), 64'h0);

    // Flush by ASID, then flush everything.
    do_reset();
    refill(27'h500, 4'd1, 1'b0, 1'b0, 1'b0, mk_pte(44'h500, 1'b0));
    refill(27'h501, 4'd1, 1'b0, 1'b0, 1'b0, mk_pte(44'h501, 1'b1));
    refill(27'h502, 4'd3, 1'b0, 1'b0, 1'b0, mk_pte(44'h502, 1'b0));
    flush_i              = 1'b1;
    asid_to_be_flushed_i = 4'd1;
    step();
    idle();
    look(39'h0_0050_0000, 4'd1);
    chk("asid_flush_gone", 64'(lu_hit_o), 64'h0);
    look(39'h0_0050_1000, 4'd1);
    expect_lu("asid_flush_global", 1'b1, mk_pte(44'h501, 1'b1), 1'b0, 1'b0, 1'b0);
    look(39'h0_0050_2000, 4'd3);
    expect_lu("asid_flush_other", 1'b1, mk_pte(44'h502, 1'b0), 1'b0, 1'b0, 1'b0);
    flush_i = 1'b1;
    step();
    idle();
    look(39'h0_0050_2000, 4'd3);
    chk("flush_all_asid3", 64'(lu_hit_o), 64'h0);
    look(39'h0_0050_1000, 4'd1);
    chk("flush_all_global", 64'(lu_hit_o), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
